// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded micro-op fields into 28-bit filter-GPU
// instruction words, queues them in a small FIFO and streams them with word
// addresses to the instruction-memory loader.
// Optional feature macro: ENC_BYPASS_EN (same-cycle pass-through when the
// FIFO is empty and the loader is ready).
module instr_encoder #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              prog_start,
  input  logic              prog_end,
  input  logic              uop_valid,
  output logic              uop_ready,
  input  logic [1:0]        op_class,
  input  logic [3:0]        cmd,
  input  logic [3:0]        rd,
  input  logic [3:0]        rn,
  input  logic [3:0]        rm,
  input  logic [13:0]       imm,
  output logic [27:0]       instr_out,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              enc_err,
  output logic              prog_done,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned WORD_W = 28;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [ADDR_W:0] WC_MAX = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [1:0] CLS_DP  = 2'b00;
  localparam logic [1:0] CLS_MEM = 2'b01;
  localparam logic [3:0] CMD_ADD = 4'b0000;
  localparam logic [3:0] CMD_MUL = 4'b0011;
  localparam logic [3:0] CMD_CNV = 4'b0100;
  localparam logic [3:0] CMD_MOV = 4'b1010;
  localparam logic [3:0] CMD_LDR = 4'b0001;
  localparam logic [3:0] CMD_STR = 4'b0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              fifo_empty, fifo_full;

  logic [WORD_W-1:0] enc_word;
  logic              legal;
  logic              accept, push, pop_fifo, emit, bypass;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(DEPTH));

  // Field packing and legality check for the presented micro-op.
  always_comb begin
    legal    = 1'b0;
    enc_word = '0;
    case (op_class)
      CLS_DP:  legal = (cmd == CMD_ADD) || (cmd == CMD_MUL) ||
                       (cmd == CMD_CNV) || (cmd == CMD_MOV);
      CLS_MEM: legal = (cmd == CMD_LDR) || (cmd == CMD_STR);
      default: legal = 1'b0;
    endcase
    enc_word[17:16] = op_class;
    enc_word[15:12] = cmd;
    enc_word[7:4]   = rd;
    if (op_class == CLS_MEM) begin
      enc_word[11:8]  = rn;
      enc_word[3:0]   = imm[3:0];
      enc_word[27:18] = imm[13:4];
    end else if (cmd == CMD_MOV) begin
      enc_word[3:0]   = imm[3:0];
      enc_word[27:18] = imm[13:4];
    end else begin
      enc_word[11:8]  = rn;
      enc_word[3:0]   = rm;
    end
  end

  assign accept = uop_valid & uop_ready;

`ifdef ENC_BYPASS_EN
  // Zero-latency path: empty FIFO, ready loader, legal micro-op in LOAD.
  assign bypass = (state == LOAD) & fifo_empty & instr_ready & accept & legal;
`else
  assign bypass = 1'b0;
`endif

  assign push     = accept & legal & ~bypass;
  assign pop_fifo = ~fifo_empty & instr_ready;
  assign emit     = pop_fifo | bypass;

  // Loader-facing word: FIFO head, or the freshly encoded word on bypass.
  always_comb begin
    instr_valid = ~fifo_empty | bypass;
    instr_out   = '0;
    if (bypass) begin
      instr_out = enc_word;
    end else if (!fifo_empty) begin
      instr_out = mem[rd_ptr];
    end
  end

  // FIFO storage; contents are don't-care while the occupancy count is zero.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= enc_word;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_fifo) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop_fifo})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Word address (wrapping) and saturating emitted-word counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      instr_addr <= '0;
      word_count <= '0;
    end else if ((state == IDLE) && prog_start) begin
      instr_addr <= '0;
      word_count <= '0;
    end else if (emit) begin
      instr_addr <= instr_addr + ADDR_W'(1);
      if (word_count != WC_MAX) begin
        word_count <= word_count + (ADDR_W + 1)'(1);
      end
    end
  end

  // Illegal micro-ops are consumed and flagged one cycle later.
  always_ff @(posedge clock) begin
    if (!reset) begin
      enc_err <= 1'b0;
    end else begin
      enc_err <= accept & ~legal;
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (prog_start) state_nxt = LOAD;
      LOAD:    if (prog_end)   state_nxt = DRAIN;
      DRAIN:   if (fifo_empty) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs decoded from the registered state.
  always_comb begin
    uop_ready = 1'b0;
    prog_done = 1'b0;
    case (state)
      LOAD:    uop_ready = ~fifo_full;
      DONE:    prog_done = 1'b1;
      default: begin
        uop_ready = 1'b0;
        prog_done = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder: a default instance (DEPTH=4,
// ADDR_W=8) and a narrow-address instance (ADDR_W=2) share all inputs.
module tb_instr_encoder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, prog_start, prog_end, uop_valid, instr_ready;
  logic [1:0]  op_class;
  logic [3:0]  cmd, rd, rn, rm;
  logic [13:0] imm;

  logic        uop_ready, instr_valid, enc_err, prog_done;
  logic [27:0] instr_out;
  logic [7:0]  instr_addr;
  logic [8:0]  word_count;

  logic        uop_ready_s, instr_valid_s, enc_err_s, prog_done_s;
  logic [27:0] instr_out_s;
  logic [1:0]  instr_addr_s;
  logic [2:0]  word_count_s;

  int checks = 0;
  int errors = 0;

  logic [35:0] mon_q [$];
  logic [29:0] mon2_q [$];

  instr_encoder #(.DEPTH(4), .ADDR_W(8)) dut (
    .clock(clock), .reset(reset), .prog_start(prog_start), .prog_end(prog_end),
    .uop_valid(uop_valid), .uop_ready(uop_ready), .op_class(op_class),
    .cmd(cmd), .rd(rd), .rn(rn), .rm(rm), .imm(imm),
    .instr_out(instr_out), .instr_addr(instr_addr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .enc_err(enc_err), .prog_done(prog_done),
    .word_count(word_count)
  );

  instr_encoder #(.DEPTH(4), .ADDR_W(2)) dut_s (
    .clock(clock), .reset(reset), .prog_start(prog_start), .prog_end(prog_end),
    .uop_valid(uop_valid), .uop_ready(uop_ready_s), .op_class(op_class),
    .cmd(cmd), .rd(rd), .rn(rn), .rm(rm), .imm(imm),
    .instr_out(instr_out_s), .instr_addr(instr_addr_s), .instr_valid(instr_valid_s),
    .instr_ready(instr_ready), .enc_err(enc_err_s), .prog_done(prog_done_s),
    .word_count(word_count_s)
  );

  // Record every word the loader takes from either instance.
  always @(posedge clock) begin
    if (reset && instr_valid && instr_ready) mon_q.push_back({instr_addr, instr_out});
    if (reset && instr_valid_s && instr_ready) mon2_q.push_back({instr_addr_s, instr_out_s});
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic send_uop(input logic [1:0] c, input logic [3:0] k, input logic [3:0] d,
                          input logic [3:0] n, input logic [3:0] m, input logic [13:0] i);
    int w = 0;
    op_class = c; cmd = k; rd = d; rn = n; rm = m; imm = i;
    uop_valid = 1'b1;
    while (!uop_ready && w < 50) begin
      cyc();
      w++;
    end
    chk("uop_ready_at_accept", 36'(uop_ready), 36'd1);
    cyc();
    uop_valid = 1'b0;
  endtask

  task automatic start_prog();
    prog_start = 1'b1;
    cyc();
    prog_start = 1'b0;
  endtask

  task automatic end_prog();
    prog_end = 1'b1;
    cyc();
    prog_end = 1'b0;
  endtask

  task automatic wait_done();
    int w = 0;
    while (!prog_done && w < 50) begin
      cyc();
      w++;
    end
    chk("prog_done_pulse", 36'(prog_done), 36'd1);
    chk("prog_done_pulse_s", 36'(prog_done_s), 36'd1);
    cyc();
    chk("prog_done_once", 36'(prog_done), 36'd0);
    chk("idle_uop_ready", 36'(uop_ready), 36'd0);
    chk("idle_uop_ready_s", 36'(uop_ready_s), 36'd0);
  endtask

  task automatic chk_word(input string tag, input logic [7:0] a, input logic [27:0] w);
    logic [35:0] got;
    got = 'x;
    if (mon_q.size() > 0) got = mon_q.pop_front();
    chk(tag, got, {a, w});
  endtask

  task automatic chk_word_s(input string tag, input logic [1:0] a, input logic [27:0] w);
    logic [29:0] got;
    got = 'x;
    if (mon2_q.size() > 0) got = mon2_q.pop_front();
    chk(tag, 36'(got), 36'({a, w}));
  endtask

  initial begin
    reset = 1'b0; prog_start = 1'b0; prog_end = 1'b0; uop_valid = 1'b0;
    instr_ready = 1'b0; op_class = '0; cmd = '0; rd = '0; rn = '0; rm = '0; imm = '0;

    // Reset state
    cyc(); cyc();
    chk("rst_uop_ready", 36'(uop_ready), 36'd0);
    chk("rst_instr_valid", 36'(instr_valid), 36'd0);
    chk("rst_instr_out", 36'(instr_out), 36'd0);
    chk("rst_instr_addr", 36'(instr_addr), 36'd0);
    chk("rst_word_count", 36'(word_count), 36'd0);
    chk("rst_enc_err", 36'(enc_err), 36'd0);
    chk("rst_prog_done", 36'(prog_done), 36'd0);

    // Single ADD
    reset = 1'b1; instr_ready = 1'b1;
    cyc();
    start_prog();
    chk("load_uop_ready", 36'(uop_ready), 36'd1);
    send_uop(2'b00, 4'b0000, 4'd3, 4'd5, 4'd1, 14'd0);
`ifndef ENC_BYPASS_EN
    chk("add_valid", 36'(instr_valid), 36'd1);
    chk("add_out", 36'(instr_out), 36'h0000531);
    chk("add_addr", 36'(instr_addr), 36'd0);
`endif
    cyc();
    chk("add_word_count", 36'(word_count), 36'd1);
    chk_word("add_emit", 8'd0, 28'h0000531);
    end_prog();
    wait_done();

    // MUL, LDR, MOV program
    start_prog();
    chk("restart_word_count", 36'(word_count), 36'd0);
    send_uop(2'b00, 4'b0011, 4'd3, 4'd5, 4'd1, 14'd0);
    send_uop(2'b01, 4'b0001, 4'd3, 4'd0, 4'd0, 14'd5);
    send_uop(2'b00, 4'b1010, 4'd3, 4'd0, 4'd0, 14'd96);
    end_prog();
    wait_done();
    chk_word("prog_mul", 8'd0, 28'h0003531);
    chk_word("prog_ldr", 8'd1, 28'h0011035);
    chk_word("prog_mov", 8'd2, 28'h018A030);
    chk("prog_word_count", 36'(word_count), 36'd3);

    // Fill the FIFO with the loader stalled
    mon_q.delete(); mon2_q.delete();
    instr_ready = 1'b0;
    start_prog();
    for (int i = 0; i < 4; i++) send_uop(2'b00, 4'b0000, 4'(i), 4'(i + 1), 4'(i + 2), 14'd0);
    op_class = 2'b00; cmd = 4'b0000; rd = 4'd4; rn = 4'd5; rm = 4'd6; uop_valid = 1'b1;
    cyc();
    chk("full_uop_ready", 36'(uop_ready), 36'd0);
    chk("full_head", 36'(instr_out), 36'h0000102);
    chk("full_valid", 36'(instr_valid), 36'd1);
    instr_ready = 1'b1;
    send_uop(2'b00, 4'b0000, 4'd4, 4'd5, 4'd6, 14'd0);
    end_prog();
    wait_done();
    chk_word("full_w0", 8'd0, 28'h0000102);
    chk_word("full_w1", 8'd1, 28'h0000213);
    chk_word("full_w2", 8'd2, 28'h0000324);
    chk_word("full_w3", 8'd3, 28'h0000435);
    chk_word("full_w4", 8'd4, 28'h0000546);
    chk("full_word_count", 36'(word_count), 36'd5);

    // Illegal micro-ops
    mon_q.delete(); mon2_q.delete();
    start_prog();
    send_uop(2'b10, 4'b0000, 4'd1, 4'd2, 4'd3, 14'd0);
    chk("ill_cls_err", 36'(enc_err), 36'd1);
    chk("ill_cls_err_s", 36'(enc_err_s), 36'd1);
    chk("ill_cls_valid", 36'(instr_valid), 36'd0);
    chk("ill_cls_addr", 36'(instr_addr), 36'd0);
    cyc();
    chk("ill_err_clear", 36'(enc_err), 36'd0);
    send_uop(2'b00, 4'b0101, 4'd1, 4'd2, 4'd3, 14'd0);
    chk("ill_dp_err", 36'(enc_err), 36'd1);
    chk("ill_dp_valid", 36'(instr_valid), 36'd0);
    send_uop(2'b01, 4'b0011, 4'd1, 4'd2, 4'd3, 14'd7);
    chk("ill_mem_err", 36'(enc_err), 36'd1);
    send_uop(2'b00, 4'b0000, 4'd2, 4'd4, 4'd6, 14'd0);
    chk("legal_after_ill_err", 36'(enc_err), 36'd0);
    end_prog();
    wait_done();
    chk_word("ill_legal_word", 8'd0, 28'h0000426);
    chk("ill_word_count", 36'(word_count), 36'd1);
    chk("ill_no_extra", 36'(mon_q.size()), 36'd0);

    // Reset mid-program with queued words
    mon_q.delete(); mon2_q.delete();
    instr_ready = 1'b0;
    start_prog();
    send_uop(2'b01, 4'b0001, 4'd1, 4'd2, 4'd0, 14'd3);
    send_uop(2'b01, 4'b0000, 4'd2, 4'd3, 4'd0, 14'd4);
    send_uop(2'b01, 4'b0001, 4'd3, 4'd4, 4'd0, 14'd5);
    chk("pre_rst_valid", 36'(instr_valid), 36'd1);
    reset = 1'b0;
    cyc();
    chk("mid_rst_valid", 36'(instr_valid), 36'd0);
    chk("mid_rst_out", 36'(instr_out), 36'd0);
    chk("mid_rst_uop_ready", 36'(uop_ready), 36'd0);
    chk("mid_rst_addr", 36'(instr_addr), 36'd0);
    reset = 1'b1;
    cyc();
    chk("post_rst_empty", 36'(instr_valid), 36'd0);
    instr_ready = 1'b1;
    start_prog();
    send_uop(2'b00, 4'b1010, 4'd1, 4'd9, 4'd9, 14'h3FFF);
    end_prog();
    wait_done();
    chk_word("restart_word", 8'd0, 28'hFFCA01F);
    chk("restart_no_stale", 36'(mon_q.size()), 36'd0);

    // Address wrap / count saturation on the narrow instance; bypass latency
    mon_q.delete(); mon2_q.delete();
    start_prog();
    op_class = 2'b00; cmd = 4'b0000; rd = 4'd1; rn = 4'd2; rm = 4'd3; imm = '0;
    uop_valid = 1'b1;
    #1;
`ifdef ENC_BYPASS_EN
    chk("bypass_same_cycle_valid", 36'(instr_valid), 36'd1);
    chk("bypass_same_cycle_out", 36'(instr_out), 36'h0000213);
`else
    chk("no_passthrough_valid", 36'(instr_valid), 36'd0);
`endif
    send_uop(2'b00, 4'b0000, 4'd1, 4'd2, 4'd3, 14'd0);
    for (int i = 2; i < 6; i++) send_uop(2'b00, 4'b0000, 4'(i), 4'd0, 4'd0, 14'd0);
    end_prog();
    wait_done();
    chk_word_s("wrap_a0", 2'd0, 28'h0000213);
    chk_word_s("wrap_a1", 2'd1, 28'h0000020);
    chk_word_s("wrap_a2", 2'd2, 28'h0000030);
    chk_word_s("wrap_a3", 2'd3, 28'h0000040);
    chk_word_s("wrap_a0_again", 2'd0, 28'h0000050);
    chk("sat_word_count_s", 36'(word_count_s), 36'd4);
    chk("wide_word_count", 36'(word_count), 36'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Packs decoded micro-op fields into the 28-bit filter-GPU instruction word consumed by control_unit, the inverse of its decode.
- Buffers encoded words in a small FIFO and streams them, with word addresses, to the instruction-memory loader.
- Sits between the host/program sequencer and instruction memory.
- Rejects illegal encodings and counts emitted words per program.

Parameters:
- DEPTH, 4, FIFO depth in words; power of two, at least 2.
- ADDR_W, 8, instruction address width; the address wraps at 2^ADDR_W.

Ports:
- Clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset; 0 = reset.
- prog_start  in  1  one-cycle pulse that opens a program; accepted only in IDLE.
- prog_end  in  1  one-cycle pulse that closes the program; accepted only in LOAD.
- uop_valid  in  1  micro-op fields are valid.
- uop_ready  out  1  encoder can accept a micro-op.
- op_class  in  2  00 = DP, 01 = MEM, 10/11 = illegal.
- cmd  in  4  DP: 0000 ADD, 0011 MUL, 0100 CONV, 1010 MOV. MEM: 0001 LDR, 0000 STR.
- rd, rn, rm  in  4 each  register fields.
- imm  in  14  MOV immediate or MEM offset.
- instr_out  out  28  encoded word, head of FIFO.
- instr_addr  out  ADDR_W  address of instr_out.
- instr_valid  out  1  instr_out and instr_addr are valid.
- instr_ready  in  1  loader accepts the word.
- enc_err  out  1  one-cycle pulse: an illegal micro-op was dropped.
- prog_done  out  1  one-cycle pulse: program fully drained.
- word_count  out  ADDR_W+1  words emitted since prog_start.

Behaviour:
- Encoding:
  - Bits [17:16] = op_class, [15:12] = cmd, [7:4] = rd.
  - DP, non-MOV: [11:8] = rn, [3:0] = rm, [27:18] = 0.
  - MOV: [11:8] = 0, [3:0] = imm[3:0], [27:18] = imm[13:4]; rn and rm are ignored.
  - MEM: [11:8] = rn, [3:0] = imm[3:0], [27:18] = imm[13:4].
- Illegal micro-op: op_class 1x, or a cmd not listed for its class.
  - It is handshaken normally (consumed), not written to the FIFO.
  - enc_err pulses on the cycle after acceptance.
- Accept: uop_valid & uop_ready. uop_ready = (state == LOAD) & !fifo_full.
- Emit: instr_valid & instr_ready pops the FIFO, increments instr_addr (mod 2^ADDR_W) and increments word_count.
- word_count saturates at 2^ADDR_W.
- Latency: an accepted legal micro-op appears on instr_out no earlier than the next cycle. FIFO order is preserved.
- FSM:
  - IDLE: prog_start -> LOAD; instr_addr and word_count clear to 0.
  - LOAD: prog_end -> DRAIN. A micro-op accepted in the same cycle as prog_end is still encoded.
  - DRAIN: uop_ready = 0; when the FIFO becomes empty after the last pop -> DONE. If the FIFO is already empty, DRAIN exits on the next cycle.
  - DONE: prog_done = 1 for exactly one cycle -> IDLE.
- prog_start outside IDLE and prog_end outside LOAD are ignored.
- FIFO full: uop_ready = 0 and nothing is lost.
- Simultaneous push and pop while full: the pop frees a slot, but uop_ready was already 0 that cycle, so no push occurs.
- Push and pop on an empty FIFO in the same cycle: the word is pushed, with no pass-through unless ENC_BYPASS_EN is defined.
- Reset (any cycle, including mid-program): state = IDLE, FIFO emptied, uop_ready = 0, instr_valid = 0, instr_out = 0, instr_addr = 0, word_count = 0, enc_err = 0, prog_done = 0.

Optional Feature:
- Macro ENC_BYPASS_EN.
- Defined: in LOAD, with the FIFO empty and instr_ready = 1, a legal accepted micro-op drives instr_out and instr_valid combinationally in the same cycle (0-cycle latency) and is not written to the FIFO.
- Undefined: minimum latency is 1 cycle; all words pass through the FIFO.

Test Plan:
- Reset low for 2 cycles, then high; prog_start; ADD with rd=3, rn=5, rm=1, instr_ready=1 -> instr_out = 28'h0000531, instr_addr = 0, word_count = 1.
- Program of MUL (rd=3, rn=5, rm=1), LDR (rd=3, rn=0, imm=5), MOV (rd=3, imm=96), then prog_end -> words 28'h0003531, 28'h0011035, 28'h018A030 at addresses 0, 1, 2; prog_done pulses once; state returns to IDLE.
- instr_ready held 0 while pushing DEPTH+1 micro-ops -> uop_ready drops after DEPTH accepts; release -> words emerge in order, none lost.
- op_class=10, or DP cmd=0101 -> enc_err pulses, no FIFO write, instr_addr unchanged.
- reset asserted with 3 words queued -> next cycle instr_valid = 0, FIFO empty; a new prog_start restarts at address 0.
- ADDR_W=2 with 5 words -> addresses 0, 1, 2, 3, 0; word_count = 4 (saturated); with ENC_BYPASS_EN defined, the first word appears in its accept cycle.
